// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM microphone recorder.
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } rec_state_t;

  // Word width for the default build (4 slots of 8-bit samples).
  localparam int unsigned PDM_DEF_WORD_W = 4 * 8;

  // Packed RAM word width for a given slot count and sample width.
  function automatic int unsigned word_width(input int unsigned spw,
                                             input int unsigned sw);
    return spw * sw;
  endfunction

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int unsigned clog2_min(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pdm_decimator.sv
// Ones-counting decimator for one PDM channel with saturating output.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM    = 150,
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                bit_valid,
  input  logic                bit_in,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int unsigned CNT_W = clog2_min(DECIM);
  localparam int unsigned ACC_W = clog2_min(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [31:0] SAT_MAX = (32'd1 << SAMPLE_W) - 32'd1;

  logic [CNT_W-1:0]    bit_cnt;
  logic [ACC_W-1:0]    acc;
  logic [31:0]         ones;
  logic [SAMPLE_W-1:0] sat_val;

  // Final ones count including the current bit, clipped to full scale.
  always_comb begin
    ones    = 32'(acc) + 32'(bit_in);
    sat_val = (ones > SAT_MAX) ? SAMPLE_W'(SAT_MAX) : SAMPLE_W'(ones);
  end

  // Accumulate sampled bits and emit a sample every DECIM bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      acc          <= '0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else if (clr) begin
      bit_cnt      <= '0;
      acc          <= '0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (bit_valid) begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt      <= '0;
          acc          <= '0;
          sample       <= sat_val;
          sample_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          acc     <= acc + ACC_W'(bit_in);
        end
      end
    end
  end

endmodule

// File: rtl/pdm_recorder.sv
// PDM microphone capture: mic clock generation, per-channel decimation,
// sample packing and buffered RAM writes in one-shot or circular mode.
module pdm_recorder
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV          = 40,
  parameter int unsigned DECIM            = 150,
  parameter int unsigned SAMPLE_W         = 8,
  parameter int unsigned NUM_CH           = 1,
  parameter int unsigned SAMPLES_PER_WORD = 4,
  parameter int unsigned NUM_WORDS        = 2830,
  parameter int unsigned ADDR_W           = 12
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 micData,
  output logic                                 mic_clk,
  input  logic                                 start,
  input  logic                                 stop,
  input  logic                                 loop_mode,
  output logic                                 ram_wr,
  output logic [ADDR_W-1:0]                    ram_addr,
  output logic [SAMPLES_PER_WORD*SAMPLE_W-1:0] ram_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 wrapped
);

  localparam int unsigned WORD_W = word_width(SAMPLES_PER_WORD, SAMPLE_W);
  localparam int unsigned DIV_W  = clog2_min(CLK_DIV);
  localparam int unsigned SLOT_W = clog2_min(SAMPLES_PER_WORD);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0]  DIV_R     = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_WORDS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SAMPLES_PER_WORD - 1);

  rec_state_t          state, state_nx;
  logic [DIV_W-1:0]    div_cnt;
  logic                loop_q;
  logic                run;
  logic                last_write;
  logic [SLOT_W-1:0]   slot;
  logic [WORD_W-1:0]   pack;
  logic [NUM_CH-1:0]   ch_bit_valid;
  logic [NUM_CH-1:0]   ch_sample_valid;
  logic [SAMPLE_W-1:0] ch_sample [NUM_CH];
  logic                smp_valid;
  logic [SAMPLE_W-1:0] smp;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx   = state;
    last_write = ram_wr && (ram_addr == ADDR_LAST);
    case (state)
      IDLE:    if (start && !stop) state_nx = RECORD;
      RECORD: begin
        if (stop)                       state_nx = IDLE;
        else if (last_write && !loop_q) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    run     = (state == RECORD) && (state_nx == RECORD);
    busy    = (state == RECORD);
    done    = (state == DONE);
    mic_clk = (div_cnt >= DIV_HALF);
  end

  // Mic clock divider; parked at 0 whenever capture is not continuing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (!run)               div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + DIV_W'(1);
  end

  // Left channel samples at the end of the mic clock high phase.
  assign ch_bit_valid[0] = run && (div_cnt == DIV_LAST);

  // Right channel samples at the end of the low phase that follows a left
  // bit; arming on the first left bit keeps L completing ahead of R.
  if (NUM_CH > 1) begin : g_stereo
    logic r_armed;

    // Arm right-channel sampling once the first left bit has been taken.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_armed <= 1'b0;
      else if (!run)            r_armed <= 1'b0;
      else if (ch_bit_valid[0]) r_armed <= 1'b1;
    end

    assign ch_bit_valid[1] = run && r_armed && (div_cnt == DIV_R);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pdm_decimator #(
      .DECIM    (DECIM),
      .SAMPLE_W (SAMPLE_W)
    ) u_dec (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (!run),
      .bit_valid    (ch_bit_valid[ch]),
      .bit_in       (micData),
      .sample_valid (ch_sample_valid[ch]),
      .sample       (ch_sample[ch])
    );
  end

  // Merge channel sample streams; channels never complete in the same cycle.
  always_comb begin
    smp_valid = 1'b0;
    smp       = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (ch_sample_valid[ch]) begin
        smp_valid = 1'b1;
        smp       = ch_sample[ch];
      end
    end
  end

  // Pack samples into slots and strobe the write when the word is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      pack   <= '0;
      ram_wr <= 1'b0;
    end else if (!run) begin
      slot   <= '0;
      pack   <= '0;
      ram_wr <= 1'b0;
    end else begin
      ram_wr <= 1'b0;
      if (smp_valid) begin
        pack[slot*SAMPLE_W +: SAMPLE_W] <= smp;
        if (slot == SLOT_LAST) begin
          slot   <= '0;
          ram_wr <= 1'b1;
        end else begin
          slot <= slot + SLOT_W'(1);
        end
      end
    end
  end

  assign ram_data = pack;

  // Write address: advances after each write, wraps in circular mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ram_addr <= '0;
    else if (!run)   ram_addr <= '0;
    else if (ram_wr) ram_addr <= (ram_addr == ADDR_LAST) ? '0 : ram_addr + ADDR_W'(1);
  end

  // Capture mode latch and sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q  <= 1'b0;
      wrapped <= 1'b0;
    end else if (state == IDLE && state_nx == RECORD) begin
      loop_q  <= loop_mode;
      wrapped <= 1'b0;
    end else if (run && last_write && loop_q) begin
      wrapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pdm_recorder.sv
// Self-checking bench for pdm_recorder: table of constant-input captures,
// stereo and saturation builds, randomized bit streams against a model,
// circular wrap, stop/restart and asynchronous reset sequences.
`timescale 1ns/1ps
module tb_pdm_recorder;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    int         rc;
    logic       wrapped;
  } wr_t;

  typedef struct {
    int         mode;
    logic [7:0] exp_word;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: base configuration ----------------
  logic       a_mic = 1'b0;
  logic       a_start, a_stop, a_loop;
  logic       a_mic_clk, a_wr, a_busy, a_done, a_wrapped;
  logic [1:0] a_addr;
  logic [7:0] a_data;

  pdm_recorder #(.CLK_DIV(4), .DECIM(4), .SAMPLE_W(4), .NUM_CH(1),
                 .SAMPLES_PER_WORD(2), .NUM_WORDS(3), .ADDR_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .micData(a_mic), .mic_clk(a_mic_clk),
    .start(a_start), .stop(a_stop), .loop_mode(a_loop), .ram_wr(a_wr),
    .ram_addr(a_addr), .ram_data(a_data), .busy(a_busy), .done(a_done),
    .wrapped(a_wrapped));

  // ---------------- DUT B: stereo ----------------
  logic       b_mic;
  logic       b_start, b_stop, b_loop;
  logic       b_mic_clk, b_wr, b_busy, b_done, b_wrapped;
  logic [1:0] b_addr;
  logic [7:0] b_data;
  assign b_mic = b_mic_clk;

  pdm_recorder #(.CLK_DIV(4), .DECIM(4), .SAMPLE_W(4), .NUM_CH(2),
                 .SAMPLES_PER_WORD(2), .NUM_WORDS(3), .ADDR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .micData(b_mic), .mic_clk(b_mic_clk),
    .start(b_start), .stop(b_stop), .loop_mode(b_loop), .ram_wr(b_wr),
    .ram_addr(b_addr), .ram_data(b_data), .busy(b_busy), .done(b_done),
    .wrapped(b_wrapped));

  // ---------------- DUT C: saturating decimation ----------------
  logic       c_mic = 1'b1;
  logic       c_start, c_stop, c_loop;
  logic       c_mic_clk, c_wr, c_busy, c_done, c_wrapped;
  logic [1:0] c_addr;
  logic [7:0] c_data;

  pdm_recorder #(.CLK_DIV(4), .DECIM(20), .SAMPLE_W(4), .NUM_CH(1),
                 .SAMPLES_PER_WORD(2), .NUM_WORDS(3), .ADDR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .micData(c_mic), .mic_clk(c_mic_clk),
    .start(c_start), .stop(c_stop), .loop_mode(c_loop), .ram_wr(c_wr),
    .ram_addr(c_addr), .ram_data(c_data), .busy(c_busy), .done(c_done),
    .wrapped(c_wrapped));

  // ---------------- stimulus driver and monitors ----------------
  int   a_mode = 0;
  logic a_bits [0:63];
  int   a_rc = 0;          // cycles since capture began (valid while busy)
  int   a_k = 0;
  int   a_done_cnt = 0;
  int   a_wrap_rc = -1;
  logic a_wrapped_prev = 1'b0;
  wr_t  a_log[$];
  wr_t  b_log[$];
  wr_t  c_log[$];
  int   b_done_cnt = 0;
  int   c_done_cnt = 0;

  // One mic bit per mic clock period, indexed from the start of capture.
  always @(negedge clk) begin
    if (a_wr) a_log.push_back('{a_addr, a_data, a_rc, a_wrapped});
    if (a_done) a_done_cnt++;
    if (a_wrapped && !a_wrapped_prev) a_wrap_rc = a_rc;
    a_wrapped_prev = a_wrapped;
    if (a_busy) begin
      a_k = a_rc / 4;
      case (a_mode)
        0:       a_mic = 1'b0;
        1:       a_mic = 1'b1;
        2:       a_mic = (a_k % 2 == 0);
        default: a_mic = a_bits[a_k % 64];
      endcase
      a_rc++;
    end else begin
      a_rc  = 0;
      a_mic = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (b_wr) b_log.push_back('{b_addr, b_data, 0, b_wrapped});
    if (b_done) b_done_cnt++;
    if (c_wr) c_log.push_back('{c_addr, c_data, 0, c_wrapped});
    if (c_done) c_done_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_a(input logic lp);
    a_loop  = lp;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_loop  = 1'b0;
  endtask

  task automatic stop_a();
    a_stop = 1'b1;
    tick();
    a_stop = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (a_busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(a_busy), 32'd0);
  endtask

  // Expected word w from the random bit table: two 4-bit ones counts.
  function automatic logic [7:0] model_word(input int w);
    int s [2];
    for (int h = 0; h < 2; h++) begin
      s[h] = 0;
      for (int b = 0; b < 4; b++) s[h] += int'(a_bits[((2*w + h) * 4 + b) % 64]);
      if (s[h] > 15) s[h] = 15;
    end
    return 8'(s[0] + 16 * s[1]);
  endfunction

  // One-shot capture of constant-pattern input on DUT A with full timing checks.
  task automatic run_oneshot_a(input string tag, input int mode, input logic [7:0] exp_word);
    int base, dbase;
    base  = a_log.size();
    dbase = a_done_cnt;
    a_mode = mode;
    start_a(1'b0);
    wait_a_idle(tag, 300);
    repeat (3) tick();
    check($sformatf("%s_nwr", tag), 32'(a_log.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < a_log.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(a_log[base+i].addr), 32'(i));
        check($sformatf("%s_data%0d", tag, i), 32'(a_log[base+i].data), 32'(exp_word));
        check($sformatf("%s_time%0d", tag, i), 32'(a_log[base+i].rc), 32'(33 + 32 * i));
      end
    end
    check($sformatf("%s_done", tag), 32'(a_done_cnt - dbase), 32'd1);
    check($sformatf("%s_addr_end", tag), 32'(a_addr), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [3];

  initial begin
    int base, dbase, n, nw;
    logic lp;

    tbl[0] = '{0, 8'h00};
    tbl[1] = '{1, 8'h44};
    tbl[2] = '{2, 8'h22};

    rst_n = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_loop = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_loop = 1'b0;
    c_start = 1'b0; c_stop = 1'b0; c_loop = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_wr",      32'(a_wr),      32'd0);
    check("rst_busy",    32'(a_busy),    32'd0);
    check("rst_done",    32'(a_done),    32'd0);
    check("rst_wrapped", 32'(a_wrapped), 32'd0);
    check("rst_mic_clk", 32'(a_mic_clk), 32'd0);
    check("rst_addr",    32'(a_addr),    32'd0);
    check("rst_data",    32'(a_data),    32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Constant-pattern one-shot captures.
    for (int v = 0; v < 3; v++) begin
      run_oneshot_a($sformatf("tbl%0d", v), tbl[v].mode, tbl[v].exp_word);
      repeat (2) tick();
    end

    // Stereo: L sees mic_clk high (all ones), R sees it low (all zeros).
    base = b_log.size();
    dbase = b_done_cnt;
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0;
    while (b_busy && n < 300) begin tick(); n++; end
    check("st_idle", 32'(b_busy), 32'd0);
    repeat (3) tick();
    check("st_nwr", 32'(b_log.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < b_log.size()) begin
        check($sformatf("st_addr%0d", i), 32'(b_log[base+i].addr), 32'(i));
        check($sformatf("st_data%0d", i), 32'(b_log[base+i].data), 32'h04);
      end
    end
    check("st_done", 32'(b_done_cnt - dbase), 32'd1);

    // Saturation: 20 ones clip to 0xF.
    base = c_log.size();
    c_start = 1'b1; tick(); c_start = 1'b0;
    n = 0;
    while (c_busy && n < 1000) begin tick(); n++; end
    check("sat_idle", 32'(c_busy), 32'd0);
    repeat (3) tick();
    check("sat_nwr", 32'(c_log.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < c_log.size())
        check($sformatf("sat_data%0d", i), 32'(c_log[base+i].data), 32'hFF);
    end

    // Random bit streams, one-shot and circular, against the model.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 64; i++) a_bits[i] = 1'($urandom_range(0, 1));
      lp = 1'(it % 2);
      nw = lp ? 5 : 3;
      base = a_log.size();
      a_mode = 3;
      start_a(lp);
      n = 0;
      while ((a_log.size() - base) < nw && n < 400) begin tick(); n++; end
      if (lp) stop_a();
      wait_a_idle($sformatf("rnd%0d", it), 50);
      repeat (3) tick();
      check($sformatf("rnd%0d_nwr", it), 32'(a_log.size() - base), 32'(nw));
      for (int w = 0; w < nw; w++) begin
        if (base + w < a_log.size()) begin
          check($sformatf("rnd%0d_addr%0d", it, w), 32'(a_log[base+w].addr), 32'(w % 3));
          check($sformatf("rnd%0d_data%0d", it, w), 32'(a_log[base+w].data), 32'(model_word(w)));
        end
      end
    end

    // Circular mode: addresses wrap, wrapped is sticky, stop gives no done.
    base = a_log.size();
    dbase = a_done_cnt;
    a_mode = 0;
    start_a(1'b1);
    n = 0;
    while ((a_log.size() - base) < 5 && n < 400) begin tick(); n++; end
    stop_a();
    check("loop_busy", 32'(a_busy), 32'd0);
    check("loop_addr", 32'(a_addr), 32'd0);
    check("loop_nwr", 32'(a_log.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < a_log.size()) begin
        check($sformatf("loop_addr%0d", i), 32'(a_log[base+i].addr), 32'(i % 3));
        check($sformatf("loop_wrap%0d", i), 32'(a_log[base+i].wrapped), 32'(i >= 3));
      end
    end
    check("loop_wrap_time", 32'(a_wrap_rc), 32'd98);
    repeat (3) tick();
    check("loop_no_done", 32'(a_done_cnt - dbase), 32'd0);
    check("loop_wrap_sticky", 32'(a_wrapped), 32'd1);

    // Stop partway through word 1, then restart from a clean state.
    base = a_log.size();
    dbase = a_done_cnt;
    a_mode = 1;
    start_a(1'b0);
    check("stop_wrap_clr", 32'(a_wrapped), 32'd0);
    n = 0;
    while (a_rc < 55 && n < 200) begin tick(); n++; end
    stop_a();
    check("stop_busy", 32'(a_busy), 32'd0);
    check("stop_addr", 32'(a_addr), 32'd0);
    repeat (100) tick();
    check("stop_nwr", 32'(a_log.size() - base), 32'd1);
    check("stop_no_done", 32'(a_done_cnt - dbase), 32'd0);
    run_oneshot_a("restart", 2, 8'h22);

    // Asynchronous reset mid-word.
    a_mode = 1;
    start_a(1'b0);
    n = 0;
    while (a_rc != 22 && n < 100) begin tick(); n++; end
    check("mid_rc", 32'(a_rc), 32'd22);
    check("mid_mic_clk", 32'(a_mic_clk), 32'd1);
    check("mid_data", 32'(a_data), 32'h04);
    rst_n = 1'b0;
    #1;
    check("arst_busy",    32'(a_busy),    32'd0);
    check("arst_mic_clk", 32'(a_mic_clk), 32'd0);
    check("arst_data",    32'(a_data),    32'd0);
    check("arst_addr",    32'(a_addr),    32'd0);
    check("arst_wr",      32'(a_wr),      32'd0);
    tick();
    rst_n = 1'b1;
    a_start = 1'b1;
    a_stop  = 1'b1;
    repeat (4) tick();
    check("start_stop_idle", 32'(a_busy), 32'd0);
    check("start_stop_mic",  32'(a_mic_clk), 32'd0);
    a_start = 1'b0;
    a_stop  = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
